// File: rtl/rst_seq_pkg.sv
// Reset sequencer shared definitions: state encoding and counter sizing helper.
// Used by rst_seq_ctrl; the RST_SEQ_REVERSE_EN build option lives in the top.
package rst_seq_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_ASSERT  = 2'd0;
    localparam logic [ST_W-1:0] ST_RELEASE = 2'd1;
    localparam logic [ST_W-1:0] ST_RUN     = 2'd2;
    localparam logic [ST_W-1:0] ST_DRAIN   = 2'd3;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rst_seq_dly_cnt.sv
// Step-spacing down-counter for the reset sequencer. A load arms it with the
// spacing value; while enabled it counts down and flags expiry on the cycle
// it sits at 1, so a load of D expires exactly D enabled edges later.
module rst_seq_dly_cnt #(
    parameter int DLY_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             en,
    input  logic [DLY_W-1:0] load_val,
    output logic             expire
);

    logic [DLY_W-1:0] cnt;

    assign expire = en && (cnt == DLY_W'(1));

    // Load has priority so an expiry can immediately re-arm the next step.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domain resets for HOLD_CYC edges, then releases
// domains 0..N-1 one per spacing interval. SW_RST_REQ re-runs the sequence.
// Build option RST_SEQ_REVERSE_EN: a request in RUN re-asserts the domains in
// reverse order (DRAIN) instead of all at once.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 3,
    parameter int DLY_W       = 8,
    parameter int HOLD_CYC    = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    input  logic [DLY_W-1:0]       DLY_CFG,
    output logic [NUM_DOMAINS-1:0] DOM_RST_N,
    output logic                   BUSY,
    output logic                   DONE
);

    localparam int HW = cnt_w(HOLD_CYC);
    localparam int IW = cnt_w(NUM_DOMAINS + 1);

    localparam logic [HW-1:0]          HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [IW-1:0]          IDX_LAST  = IW'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] TOP_MASK  = NUM_DOMAINS'(1) << (NUM_DOMAINS - 1);

    logic [ST_W-1:0]        state;
    logic [HW-1:0]          hold_cnt;
    logic [IW-1:0]          idx;
    logic [DLY_W-1:0]       d_reg;
    logic [DLY_W-1:0]       d_eff;
    logic [NUM_DOMAINS-1:0] dom_q;
    logic [NUM_DOMAINS-1:0] idx_mask;
    logic                   ctr_load;
    logic                   ctr_en;
    logic [DLY_W-1:0]       ctr_val;
    logic                   dly_exp;

    assign d_eff     = (DLY_CFG == '0) ? DLY_W'(1) : DLY_CFG;
    assign idx_mask  = NUM_DOMAINS'(1) << idx;
    assign DOM_RST_N = dom_q;
    assign BUSY      = (state != ST_RUN);
    assign DONE      = (state == ST_RUN);
    assign ctr_en    = (state == ST_RELEASE) || (state == ST_DRAIN);

    // Arm the spacing counter on entry to a stepping state (fresh DLY_CFG)
    // and re-arm it with the latched spacing after every step.
    always_comb begin
        ctr_load = 1'b0;
        ctr_val  = d_reg;
        if ((state == ST_ASSERT) && !SW_RST_REQ && (hold_cnt == HOLD_LAST)) begin
            ctr_load = 1'b1;
            ctr_val  = d_eff;
        end
`ifdef RST_SEQ_REVERSE_EN
        if ((state == ST_RUN) && SW_RST_REQ) begin
            ctr_load = 1'b1;
            ctr_val  = d_eff;
        end
`endif
        if (dly_exp)
            ctr_load = 1'b1;
    end

    rst_seq_dly_cnt #(
        .DLY_W (DLY_W)
    ) u_dly_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (ctr_load),
        .en       (ctr_en),
        .load_val (ctr_val),
        .expire   (dly_exp)
    );

    // Sequencer FSM; domain outputs only move on hold/step/request edges.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_ASSERT;
            hold_cnt <= '0;
            idx      <= '0;
            d_reg    <= DLY_W'(1);
            dom_q    <= '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (SW_RST_REQ) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_RELEASE;
                        hold_cnt <= '0;
                        idx      <= '0;
                        d_reg    <= d_eff;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (SW_RST_REQ) begin
                        state    <= ST_ASSERT;
                        hold_cnt <= '0;
                        idx      <= '0;
                        dom_q    <= '0;
                    end else if (dly_exp) begin
                        dom_q <= dom_q | idx_mask;
                        idx   <= idx + IW'(1);
                        if (idx == IDX_LAST)
                            state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (SW_RST_REQ) begin
                        hold_cnt <= '0;
`ifdef RST_SEQ_REVERSE_EN
                        // Highest domain drops first; a single domain goes straight to hold.
                        dom_q <= dom_q & ~TOP_MASK;
                        d_reg <= d_eff;
                        if (NUM_DOMAINS > 1) begin
                            state <= ST_DRAIN;
                            idx   <= IW'(NUM_DOMAINS - 2);
                        end else begin
                            state <= ST_ASSERT;
                            idx   <= '0;
                        end
`else
                        state <= ST_ASSERT;
                        idx   <= '0;
                        dom_q <= '0;
`endif
                    end
                end
`ifdef RST_SEQ_REVERSE_EN
                ST_DRAIN: begin
                    if (dly_exp) begin
                        dom_q <= dom_q & ~idx_mask;
                        if (idx == '0) begin
                            state    <= ST_ASSERT;
                            hold_cnt <= '0;
                        end else begin
                            idx <= idx - IW'(1);
                        end
                    end
                end
`endif
                default: begin
                    state    <= ST_ASSERT;
                    hold_cnt <= '0;
                    idx      <= '0;
                    dom_q    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl (NUM_DOMAINS=3, HOLD_CYC=4). A timeline model derives
// every output from edge counts since the last sequence origin; directed
// literal checks pin the release edges. Honours RST_SEQ_REVERSE_EN.
module tb_rst_seq_ctrl;

    localparam int N    = 3;
    localparam int DW   = 8;
    localparam int HOLD = 4;
`ifdef RST_SEQ_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          SW_RST_REQ;
    logic [DW-1:0] DLY_CFG;
    logic [N-1:0]  DOM_RST_N;
    logic          BUSY;
    logic          DONE;

    int n_tests = 0;
    int n_fail  = 0;
    int ed      = -1;
    bit chk_en  = 1'b0;

    rst_seq_ctrl #(.NUM_DOMAINS(N), .DLY_W(DW), .HOLD_CYC(HOLD)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SW_RST_REQ (SW_RST_REQ),
        .DLY_CFG    (DLY_CFG),
        .DOM_RST_N  (DOM_RST_N),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    // Timeline model: m_e = edges seen since the sequence origin, m_d = latched
    // spacing; in drain, m_t = edges since the drain request edge.
    int m_e, m_d, m_t, m_dd;
    bit m_drain;

    function automatic int eff(input logic [DW-1:0] v);
        return (v == 0) ? 1 : int'(v);
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_e     <= 0;
            m_d     <= 1;
            m_t     <= 0;
            m_dd    <= 1;
            m_drain <= 1'b0;
        end else if (m_drain) begin
            if (m_t + 1 >= (N - 1) * m_dd) begin
                m_drain <= 1'b0;
                m_e     <= 0;
            end else begin
                m_t <= m_t + 1;
            end
        end else if (SW_RST_REQ && (m_e >= HOLD + N * m_d) && REV) begin
            if (N == 1) begin
                m_e <= 0;
            end else begin
                m_drain <= 1'b1;
                m_t     <= 0;
                m_dd    <= eff(DLY_CFG);
            end
        end else if (SW_RST_REQ) begin
            m_e <= 0;
        end else begin
            if (m_e == HOLD - 1) m_d <= eff(DLY_CFG);
            if (m_e < 1000000) m_e <= m_e + 1;
        end
    end

    function automatic logic [N-1:0] exp_dom();
        logic [N-1:0] b;
        for (int i = 0; i < N; i++) begin
            if (m_drain) b[i] = (m_t < (N - 1 - i) * m_dd);
            else         b[i] = (m_e >= HOLD + (i + 1) * m_d);
        end
        return b;
    endfunction

    function automatic logic exp_done();
        return !m_drain && (m_e >= HOLD + N * m_d);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h, required %0h", nm, ed, got, exp);
        end
    endtask

    // Model comparison on every falling edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("model_dom",  32'(DOM_RST_N), 32'(exp_dom()));
            chk("model_done", 32'(DONE),      32'(exp_done()));
            chk("model_busy", 32'(BUSY),      32'(!exp_done()));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        ed++;
    endtask

    task automatic to_edge(input int n);
        while (ed < n) tick();
    endtask

    task automatic lit(input string nm, input int n, input logic [N-1:0] dom,
                       input logic busy, input logic done);
        to_edge(n);
        chk({nm, "_dom"},  32'(DOM_RST_N), 32'(dom));
        chk({nm, "_busy"}, 32'(BUSY),      32'(busy));
        chk({nm, "_done"}, 32'(DONE),      32'(done));
    endtask

    task automatic do_reset(input logic [DW-1:0] cfg);
        DLY_CFG = cfg;
        RST     = 1'b1;
        tick();
        RST     = 1'b0;
        ed      = -1;
    endtask

    initial begin
        RST        = 1'b1;
        SW_RST_REQ = 1'b0;
        DLY_CFG    = 8'd3;
        #1;
        chk("rst_dom",  32'(DOM_RST_N), 32'h0);
        chk("rst_busy", 32'(BUSY),      32'h1);
        chk("rst_done", 32'(DONE),      32'h0);
        chk_en = 1'b1;

        // Test 1: D=3, releases at 6, 9, 12.
        do_reset(8'd3);
        lit("t1_e5",  5,  3'b000, 1'b1, 1'b0);
        lit("t1_e6",  6,  3'b001, 1'b1, 1'b0);
        lit("t1_e8",  8,  3'b001, 1'b1, 1'b0);
        lit("t1_e9",  9,  3'b011, 1'b1, 1'b0);
        lit("t1_e11", 11, 3'b011, 1'b1, 1'b0);
        lit("t1_e12", 12, 3'b111, 1'b0, 1'b1);
        to_edge(14);

`ifdef RST_SEQ_REVERSE_EN
        // Test 6: reverse drain with D=2 from RUN, request sampled at edge 15.
        DLY_CFG    = 8'd2;
        SW_RST_REQ = 1'b1;
        tick();
        SW_RST_REQ = 1'b0;
        chk("t6_e15_dom",  32'(DOM_RST_N), 32'(3'b011));
        chk("t6_e15_busy", 32'(BUSY),      32'h1);
        chk("t6_e15_done", 32'(DONE),      32'h0);
        lit("t6_e16", 16, 3'b011, 1'b1, 1'b0);
        lit("t6_e17", 17, 3'b001, 1'b1, 1'b0);
        lit("t6_e18", 18, 3'b001, 1'b1, 1'b0);
        lit("t6_e19", 19, 3'b000, 1'b1, 1'b0);
        lit("t6_e24", 24, 3'b000, 1'b1, 1'b0);
        lit("t6_e25", 25, 3'b001, 1'b1, 1'b0);
        lit("t6_e29", 29, 3'b111, 1'b0, 1'b1);
`else
        // Test 3: request in RUN sampled at edge 15; pattern repeats from there.
        SW_RST_REQ = 1'b1;
        tick();
        SW_RST_REQ = 1'b0;
        chk("t3_e15_dom",  32'(DOM_RST_N), 32'h0);
        chk("t3_e15_busy", 32'(BUSY),      32'h1);
        lit("t3_e21", 21, 3'b000, 1'b1, 1'b0);
        lit("t3_e22", 22, 3'b001, 1'b1, 1'b0);
        lit("t3_e25", 25, 3'b011, 1'b1, 1'b0);
        lit("t3_e28", 28, 3'b111, 1'b0, 1'b1);
`endif

        // Test 2: DLY_CFG=0 behaves as 1.
        do_reset(8'd0);
        lit("t2_e3", 3, 3'b000, 1'b1, 1'b0);
        lit("t2_e4", 4, 3'b001, 1'b1, 1'b0);
        lit("t2_e5", 5, 3'b011, 1'b1, 1'b0);
        lit("t2_e6", 6, 3'b111, 1'b0, 1'b1);

        // Test 4: request between releases (sampled at 11), then again in hold (14).
        do_reset(8'd3);
        to_edge(10);
        SW_RST_REQ = 1'b1;
        tick();
        SW_RST_REQ = 1'b0;
        chk("t4_e11_dom", 32'(DOM_RST_N), 32'h0);
        to_edge(13);
        SW_RST_REQ = 1'b1;
        tick();
        SW_RST_REQ = 1'b0;
        lit("t4_e18", 18, 3'b000, 1'b1, 1'b0);
        lit("t4_e20", 20, 3'b000, 1'b1, 1'b0);
        lit("t4_e21", 21, 3'b001, 1'b1, 1'b0);
        lit("t4_e27", 27, 3'b111, 1'b0, 1'b1);

        // Test 5: async RST mid-release, checked before any clock edge.
        do_reset(8'd3);
        to_edge(9);
        #2;
        RST = 1'b1;
        #1;
        chk("t5_async_dom",  32'(DOM_RST_N), 32'h0);
        chk("t5_async_busy", 32'(BUSY),      32'h1);
        chk("t5_async_done", 32'(DONE),      32'h0);
        tick();
        RST = 1'b0;
        ed  = -1;
        lit("t5_e6",  6,  3'b001, 1'b1, 1'b0);
        lit("t5_e12", 12, 3'b111, 1'b0, 1'b1);
        to_edge(14);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
